// File: rtl/axis_checksum_appender.sv
// AXI-Stream pass-through that appends an additive checksum word (tlast=1) after each frame.
// Optional: define CHECKSUM_INV_EN to emit the bitwise inverse of the accumulator as the checksum.
module axis_checksum_appender #(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 16,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       axis_aclk,
  input  logic                       axis_areset,
  input  logic [DATA_WIDTH-1:0]      s04_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]    s04_axis_tstrb,
  input  logic                       s04_axis_tvalid,
  input  logic                       s04_axis_tlast,
  output logic                       s04_axis_tready,
  output logic [DATA_WIDTH-1:0]      m04_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]    m04_axis_tstrb,
  output logic                       m04_axis_tvalid,
  output logic                       m04_axis_tlast,
  input  logic                       m04_axis_tready,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int EW     = 1 + STRB_W + DATA_WIDTH;

  typedef enum logic {ST_PASS, ST_CSUM} state_t;

  state_t                     state_q, state_d;
  logic [EW-1:0]              mem_q [FIFO_DEPTH];
  logic [AW:0]                wr_ptr_q, wr_ptr_d;
  logic [AW:0]                rd_ptr_q, rd_ptr_d;
  logic                       fifo_full_q, fifo_full_d;
  logic [DATA_WIDTH-1:0]      acc_q, acc_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

  logic                  fifo_empty;
  logic                  push;
  logic [EW-1:0]         head;
  logic                  head_last;
  logic [STRB_W-1:0]     head_strb;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] head_masked;
  logic [DATA_WIDTH-1:0] csum_word;

  assign fifo_empty      = (wr_ptr_q == rd_ptr_q);
  assign s04_axis_tready = !fifo_full_q && !axis_areset;
  assign push            = s04_axis_tvalid && s04_axis_tready;
  assign head            = mem_q[rd_ptr_q[AW-1:0]];
  assign head_last       = head[EW-1];
  assign head_strb       = head[DATA_WIDTH +: STRB_W];
  assign head_data       = head[DATA_WIDTH-1:0];
  assign frame_cnt       = frame_cnt_q;

`ifdef CHECKSUM_INV_EN
  assign csum_word = ~acc_q;
`else
  assign csum_word = acc_q;
`endif

  always_comb begin
    head_masked = '0;
    for (int b = 0; b < STRB_W; b++) begin
      head_masked[b*8 +: 8] = head_strb[b] ? head_data[b*8 +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    frame_cnt_d     = frame_cnt_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    m04_axis_tvalid = 1'b0;
    m04_axis_tdata  = '0;
    m04_axis_tstrb  = '0;
    m04_axis_tlast  = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    case (state_q)
      ST_PASS: begin
        if (!fifo_empty) begin
          m04_axis_tvalid = 1'b1;
          m04_axis_tdata  = head_data;
          m04_axis_tstrb  = head_strb;
          if (m04_axis_tready) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            acc_d    = acc_q + head_masked;
            if (head_last) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        m04_axis_tvalid = 1'b1;
        m04_axis_tdata  = csum_word;
        m04_axis_tstrb  = '1;
        m04_axis_tlast  = 1'b1;
        if (m04_axis_tready) begin
          acc_d       = '0;
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = ST_PASS;
        end
      end
      default: state_d = ST_PASS;
    endcase

    // Full flag is registered from the next-cycle pointers so tready has no input path.
    fifo_full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q     <= ST_PASS;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_full_q <= 1'b0;
      acc_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_full_q <= fifo_full_d;
      acc_q       <= acc_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {s04_axis_tlast, s04_axis_tstrb, s04_axis_tdata};
  end

endmodule

// File: tb/tb_axis_checksum_appender.sv
// Scoreboard bench for axis_checksum_appender: expected words queued on input accept,
// compared as the DUT emits them.
module tb_axis_checksum_appender;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tstrb = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic [15:0] frame_cnt;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_acc = '0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          accepted = 0;
  int          ready_mode = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d = '0;
  logic [3:0]  prev_s = '0;
  logic        prev_l = 1'b0;

  axis_checksum_appender dut (
    .axis_aclk       (clk),
    .axis_areset     (areset),
    .s04_axis_tdata  (s_tdata),
    .s04_axis_tstrb  (s_tstrb),
    .s04_axis_tvalid (s_tvalid),
    .s04_axis_tlast  (s_tlast),
    .s04_axis_tready (s_tready),
    .m04_axis_tdata  (m_tdata),
    .m04_axis_tstrb  (m_tstrb),
    .m04_axis_tvalid (m_tvalid),
    .m04_axis_tlast  (m_tlast),
    .m04_axis_tready (m_tready),
    .frame_cnt       (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] masked(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
    return m;
  endfunction

  function automatic logic [31:0] csum_of(input logic [31:0] a);
`ifdef CHECKSUM_INV_EN
    return ~a;
`else
    return a;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {63'd0, m_tvalid}, 64'd1);
        chk("hold_data", {32'd0, m_tdata}, {32'd0, prev_d});
        chk("hold_strb_last", {59'd0, m_tstrb, m_tlast}, {59'd0, prev_s, prev_l});
      end
      if (!m_tvalid) begin
        chk("idle_data_zero", {27'd0, m_tdata, m_tstrb, m_tlast}, 64'd0);
      end else if (m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("m_tdata", {32'd0, m_tdata}, {32'd0, e.d});
          chk("m_tstrb", {60'd0, m_tstrb}, {60'd0, e.s});
          chk("m_tlast", {63'd0, m_tlast}, {63'd0, e.l});
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_s = m_tstrb;
      prev_l = m_tlast;
    end
  end

  task automatic send(input logic [31:0] d, input logic [3:0] s, input logic l);
    bit done;
    int n;
    done = 0;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata = d;
    s_tstrb = s;
    s_tlast = l;
    while (!done && n < 300) begin
      @(negedge clk);
      if (s_tready) done = 1;
      else n++;
    end
    if (!done) chk("send_timeout", {63'd0, s_tready}, 64'd1);
    @(posedge clk);
    #1;
    if (done) begin
      accepted++;
      exp_q.push_back('{d: d, s: s, l: 1'b0});
      model_acc = model_acc + masked(d, s);
      if (l) begin
        exp_q.push_back('{d: csum_of(model_acc), s: 4'hF, l: 1'b1});
        model_acc = '0;
      end
    end
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tstrb = '0;
    s_tlast = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_s_tready", {63'd0, s_tready}, 64'd0);
    areset = 1'b0;
    @(negedge clk);
    chk("reset_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("reset_m_out", {27'd0, m_tdata, m_tstrb, m_tlast}, 64'd0);
    chk("reset_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    chk("post_reset_s_tready", {63'd0, s_tready}, 64'd1);
    @(posedge clk);
    #1;

    // basic four-word frame
    for (int i = 1; i <= 4; i++) send(32'(i), 4'hF, i == 4);
    wait_drain();
    chk("frame_cnt_1", {48'd0, frame_cnt}, 64'd1);

    // modular wrap
    send(32'hFFFF_FFFF, 4'hF, 1'b0);
    send(32'h0000_0002, 4'hF, 1'b1);
    wait_drain();
    chk("frame_cnt_2", {48'd0, frame_cnt}, 64'd2);

    // single word, partial strobe
    send(32'h1122_3344, 4'h3, 1'b1);
    wait_drain();
    chk("frame_cnt_3", {48'd0, frame_cnt}, 64'd3);

    // stall: FIFO fills to 16, then drains in order
    ready_mode = 2;
    @(posedge clk);
    #1;
    accepted = 0;
    fork
      for (int i = 0; i < 20; i++) send(32'(100 + i), 4'hF, i == 19);
      begin
        repeat (40) @(negedge clk);
        chk("stall_accepted", 64'(accepted), 64'd16);
        chk("stall_s_tready", {63'd0, s_tready}, 64'd0);
        chk("stall_head", {32'd0, m_tdata}, 64'd100);
        ready_mode = 0;
      end
    join
    wait_drain();
    chk("stall_accepted_all", 64'(accepted), 64'd20);
    chk("frame_cnt_4", {48'd0, frame_cnt}, 64'd4);

    // back-to-back frames with toggling ready
    ready_mode = 1;
    send(32'd5, 4'hF, 1'b0);
    send(32'd6, 4'hF, 1'b1);
    send(32'd7, 4'hF, 1'b1);
    wait_drain();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("frame_cnt_6", {48'd0, frame_cnt}, 64'd6);

    // reset mid-frame discards buffered words
    ready_mode = 2;
    @(posedge clk);
    #1;
    send(32'h21, 4'hF, 1'b0);
    send(32'h22, 4'hF, 1'b0);
    areset = 1'b1;
    @(negedge clk);
    chk("midreset_s_tready", {63'd0, s_tready}, 64'd0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    exp_q.delete();
    model_acc = '0;
    @(negedge clk);
    chk("midreset_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("midreset_m_out", {27'd0, m_tdata, m_tstrb, m_tlast}, 64'd0);
    chk("midreset_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    ready_mode = 0;
    @(posedge clk);
    #1;
    send(32'd9, 4'hF, 1'b1);
    wait_drain();
    chk("frame_cnt_after_reset", {48'd0, frame_cnt}, 64'd1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
